// File: rtl/moldudp64_msg_pack_if.sv
// rtl/moldudp64_msg_pack_if.sv - message-in / packed-beat-out bundle for moldudp64_msg_pack
// Purpose: groups the message input stream, packed output stream and status.
// Modports: slave = packer side (consumes in_*, produces out_*/status),
//           master = environment side (message source and beat sink).
interface moldudp64_msg_pack_if #(
  parameter int P_L  = 8,
  parameter int ML_W = 16,
  parameter int MC_W = 16
);
  logic                in_valid_i;
  logic                in_ready_o;
  logic [P_L*8-1:0]    in_data_i;
  logic [P_L-1:0]      in_keep_i;
  logic                in_start_i;
  logic [ML_W-1:0]     in_len_i;
  logic                in_last_i;
  logic                in_pkt_end_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [P_L*8-1:0]    out_data_o;
  logic [P_L-1:0]      out_keep_o;
  logic                out_last_o;
  logic [MC_W-1:0]     msg_cnt_o;
  logic                len_err_o;

  modport slave (
    input  in_valid_i, in_data_i, in_keep_i, in_start_i, in_len_i,
           in_last_i, in_pkt_end_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_keep_o, out_last_o,
           msg_cnt_o, len_err_o
  );

  modport master (
    output in_valid_i, in_data_i, in_keep_i, in_start_i, in_len_i,
           in_last_i, in_pkt_end_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_keep_o, out_last_o,
           msg_cnt_o, len_err_o
  );
endinterface

// File: rtl/moldudp64_msg_pack.sv
// rtl/moldudp64_msg_pack.sv - MoldUDP64 message block packer (length prefix + contiguous beats)
// Purpose: prefixes each message with its 2-byte big-endian length and packs the
//          byte stream contiguously into P_L-byte beats; reports messages per packet.
// Ports: clk, nreset (async active-low), bus (slave modport: in_* message stream,
//        out_* packed stream, msg_cnt_o, len_err_o).
module moldudp64_msg_pack #(
  parameter int P_L  = 8,
  parameter int ML_W = 16,
  parameter int MC_W = 16
) (
  input logic                 clk,
  input logic                 nreset,
  moldudp64_msg_pack_if.slave bus
);
  localparam int DEPTH = 3 * P_L;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int BW    = DEPTH * 8;
  localparam int PB    = (P_L + 2) * 8;

  // Byte FIFO held as a flat vector; head byte in [7:0]. Bytes at or above
  // fill_q are kept zero so the output beat needs no extra masking.
  logic [BW-1:0]   buf_q, buf_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            flush_q, flush_d;
  logic [MC_W-1:0] cnt_q, cnt_d;
  logic [ML_W-1:0] sum_q, sum_d;
  logic [ML_W-1:0] len_q, len_d;
  logic            len_err_q, len_err_d;

  logic             in_acc, out_valid, out_hs;
  logic [FW-1:0]    keep_n, push_n, pop_n, rem_n;
  logic [P_L*8-1:0] data_m;
  logic [PB-1:0]    push_v;
  logic [15:0]      len16;
  logic [ML_W-1:0]  msg_sum, len_cmp;

  // Worst-case push is P_L+2 bytes, so admitting only at fill <= 2*P_L-2
  // keeps the FIFO from overflowing.
  assign bus.in_ready_o  = nreset & ~flush_q & (fill_q <= FW'(2 * P_L - 2));
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = buf_q[P_L*8-1:0];
  assign bus.out_keep_o  = ~({P_L{1'b1}} << fill_q);
  assign bus.out_last_o  = flush_q & (fill_q <= FW'(P_L));
  assign bus.msg_cnt_o   = cnt_q;
  assign bus.len_err_o   = len_err_q;

  always_comb begin
    in_acc    = bus.in_valid_i & bus.in_ready_o;
    out_valid = (fill_q >= FW'(P_L)) | (flush_q & (fill_q != '0));
    out_hs    = out_valid & bus.out_ready_i;

    keep_n = '0;
    data_m = '0;
    for (int k = 0; k < P_L; k++) begin
      keep_n = keep_n + FW'(bus.in_keep_i[k]);
      if (bus.in_keep_i[k]) data_m[k*8 +: 8] = bus.in_data_i[k*8 +: 8];
    end

    len16  = 16'(bus.in_len_i);
    push_v = '0;
    push_n = '0;
    if (in_acc) begin
      if (bus.in_start_i) begin
        // High length byte goes first on the wire.
        push_v = {data_m, len16[7:0], len16[15:8]};
        push_n = keep_n + FW'(2);
      end else begin
        push_v = PB'(data_m);
        push_n = keep_n;
      end
    end

    pop_n = '0;
    if (out_hs) pop_n = (fill_q >= FW'(P_L)) ? FW'(P_L) : fill_q;
    rem_n = fill_q - pop_n;

    // Pop shifts the head out; pushed bytes land right after what remains.
    buf_d  = (buf_q >> {pop_n, 3'b000}) | (BW'(push_v) << {rem_n, 3'b000});
    fill_d = rem_n + push_n;

    msg_sum   = (bus.in_start_i ? '0 : sum_q) + ML_W'(keep_n);
    len_cmp   = bus.in_start_i ? bus.in_len_i : len_q;
    sum_d     = in_acc ? msg_sum : sum_q;
    len_d     = (in_acc & bus.in_start_i) ? bus.in_len_i : len_q;
    len_err_d = in_acc & bus.in_last_i & (msg_sum != len_cmp);

    flush_d = flush_q;
    cnt_d   = cnt_q;
    if (in_acc & bus.in_last_i & bus.in_pkt_end_i) flush_d = 1'b1;
    if (in_acc & bus.in_start_i & ~(&cnt_q)) cnt_d = cnt_q + MC_W'(1);
    // Accept and flush completion are mutually exclusive (ready is low in flush).
    if (out_hs & bus.out_last_o) begin
      flush_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      buf_q     <= '0;
      fill_q    <= '0;
      flush_q   <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      flush_q   <= flush_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end
endmodule

// File: doc/moldudp64_msg_pack.md
Name: moldudp64_msg_pack

Overview:
- Transmit-side packer for MoldUDP64 message blocks: the inverse of the receive-side message splitter and overlap detection.
- Takes a stream of messages and emits each as a 2-byte big-endian length prefix followed by its payload bytes.
- Packs bytes contiguously into P_L-byte AXI-stream beats, so messages straddle beat boundaries freely.
- Sits between the message source and the UDP payload builder; reports the per-packet message count for the header.

Parameters:
- P_L, 8: payload beat width in bytes; data bus is P_L*8 bits, keep is P_L bits.
- ML_W, 16: message length field width in bits; the prefix is always emitted as 2 bytes.
- MC_W, 16: message count width.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
- in_data_i  in  P_L*8  message bytes; byte 0 is in [7:0] and goes first on the wire
- in_keep_i  in  P_L  byte enables, contiguous from bit 0
- in_start_i  in  1  first beat of a message
- in_len_i  in  ML_W  message length in bytes; sampled with in_start_i
- in_last_i  in  1  last beat of a message
- in_pkt_end_i  in  1  this message closes the packet; sampled with in_last_i
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  output beat consumed when out_valid_o & out_ready_i
- out_data_o  out  P_L*8  packed bytes, same byte order as input
- out_keep_o  out  P_L  contiguous byte enables; all ones except possibly on the last beat
- out_last_o  out  1  final beat of the packet
- msg_cnt_o  out  MC_W  number of messages in the packet; valid while out_last_o
- len_err_o  out  1  one-cycle pulse on a length mismatch

Behaviour:
- Internal byte FIFO of depth 3*P_L, tracked by fill_q in the range 0..3*P_L. Head byte is at out_data_o[7:0].
- Reset (nreset low, async):
  - fill_q=0, flush_q=0, msg count=0, buffer cleared.
  - out_valid_o=0, out_data_o=0, out_keep_o=0, out_last_o=0, msg_cnt_o=0, len_err_o=0, in_ready_o=0.
- in_ready_o = nreset & ~flush_q & (fill_q <= 2*P_L-2). Worst-case push is P_L+2 bytes, so the FIFO never overflows.
- Push on accept:
  - bytes = popcount(in_keep_i), plus 2 if in_start_i.
  - On a start beat the prefix {in_len_i[15:8], in_len_i[7:0]} is written first, then the data bytes.
- Pop:
  - out_valid_o = (fill_q >= P_L) | (flush_q & fill_q != 0).
  - On handshake, remove min(fill_q, P_L) bytes.
- Simultaneous push and pop: fill_next = fill_q - pop + push. Pushed bytes append after the bytes remaining post-pop. Zero latency penalty: a beat is presentable the cycle after fill reaches P_L.
- Output on a partial beat: out_keep_o = (1<<fill_q)-1, unused data bytes are 0.
- Flush:
  - An accepted beat with in_last_i & in_pkt_end_i sets flush_q.
  - While flush_q, out_last_o = (fill_q <= P_L).
  - The handshake on that beat clears flush_q and the message count.
  - In_ready_o stays low throughout flush, so the next packet waits.
- Message count:
  - Increments on each accepted in_start_i, saturating at all ones.
  - msg_cnt_o is the registered count, valid while out_last_o.
  - If a packet's first start beat arrives in the same cycle the previous flush completes, that is impossible: ready is low.
- Length check:
  - Bytes are summed per message, counting from the start beat through the last beat.
  - At in_last_i accept, if sum != in_len_i, len_err_o pulses high for exactly one cycle on the next clock edge.
  - Packing still uses the actual bytes; no truncation or padding.
- Zero-length message: in_start_i & in_last_i with in_keep_i=0 pushes the 2 prefix bytes only.
- Non-contiguous keep and a missing start beat produce undefined results; formal assumptions exclude them.
- Reset mid-packet discards all buffered bytes; the first beat after reset must be a start beat.

Test Plan:
- Single 6-byte message B0..B5, pkt_end, out_ready_i=1 -> one beat with bytes 00,06,B0..B5; keep FF, last=1, msg_cnt_o=1.
- Messages of 6 and 10 bytes, second with pkt_end -> beat1 00,06,B0..B5 (keep FF); beat2 00,0A,C0..C5 (keep FF); beat3 C6..C9 (keep 0F, last=1); msg_cnt_o=2.
- Continuous 8-byte messages with out_ready_i low for 5 cycles -> in_ready_o drops once fill_q > 14; no loss or reorder; output matches a byte-queue model and fill_q never exceeds 24.
- Zero-length message with pkt_end -> one beat with bytes 00,00; keep 03, last=1, msg_cnt_o=1; len_err_o stays 0.
- in_len_i=5 but 4 bytes delivered -> len_err_o high exactly one cycle; output carries prefix 00,05 plus 4 bytes (keep 3F, last=1).
- nreset low while fill_q=12 mid-packet -> outputs go to 0 immediately; after release the next 6-byte packet emits exactly as in the first scenario, msg_cnt_o=1.
